// File: rtl/mm_job_scheduler.sv
// rtl/mm_job_scheduler.sv - round-robin owner arbitration and enable/done sequencing for the matrix-multiply accelerator
// Also runs the per-job watchdog and reports job status and the completed-job count.
module mm_job_scheduler #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WD_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] start_i,
  input  logic [N_REQ-1:0] release_i,
  input  logic             mm_done_i,
  output logic             mm_enable_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_id_o,
  output logic             busy_o,
  output logic             result_vld_o,
  output logic             job_done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] jobs_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RUN,
    S_DONE,
    S_ERR,
    S_CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [WD_W-1:0]  wdog_q;
  logic             job_done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] jobs_cnt_q;

  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             owner_req;
  logic             owner_start;
  logic             owner_release;
  logic             wdog_expired;

  assign owner_req     = req_i[grant_id_q];
  assign owner_start   = start_i[grant_id_q];
  assign owner_release = release_i[grant_id_q];
  assign wdog_expired  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_GRANT;
      S_GRANT: begin
        if (!owner_req) begin
          state_d = S_CLEAR;
        end else if (owner_start && !mm_done_i) begin
          state_d = S_RUN;
        end
      end
      // Done has priority over an expiring watchdog in the same cycle.
      S_RUN: begin
        if (mm_done_i) begin
          state_d = S_DONE;
        end else if (wdog_expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  if (owner_release || !owner_req) state_d = S_CLEAR;
      S_ERR:   state_d = S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      job_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      jobs_cnt_q <= '0;
    end else begin
      job_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q    <= N_REQ'(1) << win_id;
            grant_id_q <= win_id;
          end
        end
        S_GRANT: begin
          if (state_d == S_RUN) wdog_q <= '0;
        end
        S_RUN: begin
          wdog_q <= wdog_q + WD_W'(1);
          if (mm_done_i) begin
            job_done_q <= 1'b1;
            jobs_cnt_q <= jobs_cnt_q + CNT_W'(1);
          end
        end
        S_ERR: timeout_q <= 1'b1;
        S_CLEAR: begin
          if (grant_id_q == ID_W'(N_REQ - 1)) begin
            rr_ptr_q <= '0;
          end else begin
            rr_ptr_q <= grant_id_q + ID_W'(1);
          end
        end
        default: ;
      endcase
      if (state_d == S_CLEAR) grant_q <= '0;
    end
  end

  // Decoded from state so the async reset drops the enable immediately.
  assign mm_enable_o  = (state_q == S_RUN) || (state_q == S_DONE);
  assign busy_o       = (state_q == S_RUN);
  assign result_vld_o = (state_q == S_DONE);
  assign grant_o      = grant_q;
  assign grant_id_o   = grant_id_q;
  assign job_done_o   = job_done_q;
  assign timeout_o    = timeout_q;
  assign jobs_cnt_o   = jobs_cnt_q;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// tb/tb_mm_job_scheduler.sv - scoreboard bench for mm_job_scheduler
module tb_mm_job_scheduler;

  localparam int N_REQ = 2;
  localparam int TO    = 24;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] start;
  logic [N_REQ-1:0] rel;
  logic             done;
  logic             mm_enable_o;
  logic [N_REQ-1:0] grant_o;
  logic [0:0]       grant_id_o;
  logic             busy_o;
  logic             result_vld_o;
  logic             job_done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] jobs_cnt_o;

  mm_job_scheduler #(
    .N_REQ(N_REQ),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .req_i(req),
    .start_i(start),
    .release_i(rel),
    .mm_done_i(done),
    .mm_enable_o(mm_enable_o),
    .grant_o(grant_o),
    .grant_id_o(grant_id_o),
    .busy_o(busy_o),
    .result_vld_o(result_vld_o),
    .job_done_o(job_done_o),
    .timeout_o(timeout_o),
    .jobs_cnt_o(jobs_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_timeout;
    int id;
    int cnt;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_ptr   = 0;
  int  m_cnt   = 0;
  bit  prev_busy = 1'b0;
  bit  prev_jd   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
    for (int i = 0; i < N_REQ; i++) begin
      if (r[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on job completion or watchdog abort.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_jd   = 1'b0;
    end else begin
      if (grant_o == '0) check("en_without_grant", mm_enable_o, 0);
      else check("grant_onehot", $onehot(grant_o), 1);
      if (prev_jd) check("job_done_pulse", job_done_o, 0);
      if (job_done_o || (prev_busy && !busy_o)) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("outcome_timeout", {31'd0, !job_done_o}, {31'd0, e.is_timeout});
          check("owner_id", grant_id_o, e.id);
          check("jobs_cnt", jobs_cnt_o, e.cnt);
          if (e.is_timeout) check("err_grant", grant_o, 32'(1) << e.id);
        end
      end
      prev_busy = busy_o;
      prev_jd   = job_done_o;
    end
  end

  task automatic get_grant(input logic [N_REQ-1:0] reqv, output int id);
    int exp;
    req = reqv;
    exp = pick(reqv, m_ptr);
    for (int i = 0; i < 10; i++) begin
      if (grant_o != '0) break;
      tick();
    end
    check("grant_vec", grant_o, 32'(1) << exp);
    check("grant_id", grant_id_o, exp);
    check("grant_no_enable", mm_enable_o, 0);
    id = exp;
  endtask

  // Entered in GRANT; leaves the bench at CLEAR (posedge+1).
  task automatic do_job(input int id, input int k, input bit timeout_job, input bit use_release);
    sb_t e;
    start[id] = 1'b1;
    e.id = id;
    e.is_timeout = timeout_job;
    if (!timeout_job) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    e.cnt = m_cnt;
    sb.push_back(e);
    tick();
    start = '0;
    check("busy_run", busy_o, 1);
    if (!timeout_job) begin
      for (int i = 1; i < k; i++) begin
        check("en_run", mm_enable_o, 1);
        tick();
      end
      done = 1'b1;
      tick();
      check("result_vld", result_vld_o, 1);
      check("en_done", mm_enable_o, 1);
      rel[1 - id] = 1'b1;
      tick();
      rel = '0;
      check("nonowner_release", result_vld_o, 1);
      if (use_release) rel[id] = 1'b1;
      else req[id] = 1'b0;
      tick();
      rel  = '0;
      done = 1'b0;
    end else begin
      repeat (TO - 1) tick();
      check("busy_last_run", busy_o, 1);
      tick();
      check("err_busy", busy_o, 0);
      check("err_enable", mm_enable_o, 0);
      tick();
      check("timeout_set", timeout_o, 1);
    end
    check("clear_grant", grant_o, 0);
    check("clear_enable", mm_enable_o, 0);
    m_ptr = (id + 1) % N_REQ;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    int id;
    rst_n = 1'b0;
    req   = '0;
    start = '0;
    rel   = '0;
    done  = 1'b0;
    #12;
    check("rst_grant", grant_o, 0);
    check("rst_enable", mm_enable_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_cnt", jobs_cnt_o, 0);
    rst_n = 1'b1;
    tick();

    // Single job, grant latency of one cycle
    req = 2'b01;
    check("grant_before_edge", grant_o, 0);
    tick();
    check("grant_plus1", grant_o, 2'b01);
    do_job(0, 20, 1'b0, 1'b1);
    req = '0;
    tick();
    check("idle_grant", grant_o, 0);
    check("jobs_after_first", jobs_cnt_o, 1);

    // Non-owner pulses and a stale done in GRANT
    get_grant(2'b01, id);
    start[1] = 1'b1;
    tick();
    start = '0;
    check("nonowner_start", busy_o, 0);
    rel[1] = 1'b1;
    tick();
    rel = '0;
    check("nonowner_rel_grant", grant_o, 2'b01);
    done = 1'b1;
    start[0] = 1'b1;
    tick();
    start = '0;
    done  = 1'b0;
    check("stale_done_start", busy_o, 0);
    check("stale_done_grant", grant_o, 2'b01);
    do_job(id, 5, 1'b0, 1'b0);
    tick();
    // Owner abandons in GRANT
    get_grant(2'b01, id);
    req = '0;
    tick();
    check("abandon_grant", grant_o, 0);
    check("abandon_busy", busy_o, 0);
    m_ptr = (id + 1) % N_REQ;
    tick();

    // Done on the final watchdog cycle wins
    get_grant(2'b01, id);
    do_job(id, TO, 1'b0, 1'b1);
    req = '0;
    check("boundary_no_timeout", timeout_o, 0);
    tick();

    // Watchdog abort, then the other requester is served round-robin
    get_grant(2'b11, id);
    do_job(id, 0, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      get_grant(2'b11, id);
      do_job(id, 3 + j, 1'b0, 1'b1);
    end
    req = '0;
    tick();
    check("timeout_sticky", timeout_o, 1);

    // Async reset mid-RUN, then counter wrap
    get_grant(2'b01, id);
    start[id] = 1'b1;
    tick();
    start = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_enable", mm_enable_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_grant", grant_o, 0);
    check("arst_grant_id", grant_id_o, 0);
    check("arst_timeout", timeout_o, 0);
    check("arst_cnt", jobs_cnt_o, 0);
    check("arst_vld", {30'd0, result_vld_o, job_done_o}, 0);
    sb.delete();
    req   = '0;
    done  = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    #3 rst_n = 1'b1;
    tick();
    for (int j = 0; j < 4; j++) begin
      get_grant(2'b01, id);
      do_job(id, 2, 1'b0, 1'b0);
    end
    tick();
    check("cnt_wrap", jobs_cnt_o, 0);
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
